// File: rtl/timer_fsm_param_pkg.sv
// timer_pkg: shared types and defaults for the timer_fsm_param block.
//   state_t           - 2-bit FSM state (IDLE=0, COUNTING=1, PAUSED=2, DONE=3)
//   STATE_*           - the same encodings as plain 2-bit constants
//   DEFAULT_WIDTH     - default counter width
//   DEFAULT_PRESCALE  - default enabled cycles per decrement
//   prescale_bits()   - width of the prescaler divider register
package timer_pkg;

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_COUNTING = 2'd1;
    localparam logic [1:0] STATE_PAUSED   = 2'd2;
    localparam logic [1:0] STATE_DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = STATE_IDLE,
        ST_COUNTING = STATE_COUNTING,
        ST_PAUSED   = STATE_PAUSED,
        ST_DONE     = STATE_DONE
    } state_t;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_PRESCALE = 1;

    // ceil(log2(p)) with a floor of one bit so PRESCALE=1 still gets a register.
    function automatic int prescale_bits(input int p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/timer_fsm_param_if.sv
// timer_fsm_param_if: control/status bundle between the register front-end
// and the timer.
//   master modport (front-end): drives enable, start, clear, load_value;
//                               observes count, state, busy, trigger.
//   slave modport  (timer):     the mirror image.
interface timer_fsm_param_if #(
    parameter int WIDTH = timer_pkg::DEFAULT_WIDTH
);
    logic             enable;
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             trigger;

    modport master (
        output enable, start, clear, load_value,
        input  count, state, busy, trigger
    );

    modport slave (
        input  enable, start, clear, load_value,
        output count, state, busy, trigger
    );
endinterface

// File: rtl/timer_fsm_param_prescaler.sv
// timer_prescaler: tick divider for the timer.
//   clk     - clock
//   reset   - asynchronous active-low reset
//   run     - count this cycle (timer counting and enabled)
//   restart - return the divider to 0 (takes precedence over run)
//   tick    - high on the run cycle that completes PRESCALE enabled cycles
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);
    localparam int            PW   = prescale_bits(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] div_reg;
    logic [PW-1:0] div_next;

    assign tick = run && !restart && (div_reg == LAST);

    always_comb begin
        div_next = div_reg;
        if (restart) begin
            div_next = '0;
        end else if (run) begin
            div_next = tick ? '0 : div_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end
endmodule

// File: rtl/timer_fsm_param.sv
// timer_fsm_param: parametrised down-counting timer with prescaler.
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous active-low reset
//   bus   - timer_fsm_param_if.slave: enable/start/clear/load_value in,
//           count/state/busy/trigger out (all registered or state-decoded)
// Optional feature: define TIMER_FSM_AUTORELOAD_EN to make DONE a one-cycle
// state that reloads load_value and keeps running; otherwise DONE is sticky.
module timer_fsm_param
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic               clk,
    input  logic               reset,
    timer_fsm_param_if.slave   bus
);
    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             run;
    logic             restart;
    logic             reload;
    logic             tick;

    // run/restart are kept out of the FSM process so the prescaler's tick
    // feeding back into it does not form a combinational loop.
    assign run = (state_reg == ST_COUNTING) && bus.enable && !bus.clear && !bus.start;

`ifdef TIMER_FSM_AUTORELOAD_EN
    assign reload = (state_reg == ST_DONE) && (bus.load_value != '0);
`else
    assign reload = 1'b0;
`endif

    assign restart = bus.clear || bus.start || reload;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (bus.clear) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (bus.start) begin
            count_next = bus.load_value;
            if (bus.load_value == '0) begin
                state_next = ST_DONE;
            end else begin
                state_next = bus.enable ? ST_COUNTING : ST_PAUSED;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_COUNTING: begin
                    if (!bus.enable) begin
                        state_next = ST_PAUSED;
                    end else if (tick) begin
                        // Expiry lands in DONE on the same edge as the 1->0 step.
                        if (count_reg <= WIDTH'(1)) begin
                            count_next = '0;
                            state_next = ST_DONE;
                        end else begin
                            count_next = count_reg - WIDTH'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    // Resume edge itself never decrements.
                    if (bus.enable) begin
                        state_next = ST_COUNTING;
                    end
                end
                ST_DONE: begin
                    if (reload) begin
                        count_next = bus.load_value;
                        state_next = bus.enable ? ST_COUNTING : ST_PAUSED;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    assign bus.count   = count_reg;
    assign bus.state   = state_reg;
    assign bus.busy    = (state_reg == ST_COUNTING) || (state_reg == ST_PAUSED);
    assign bus.trigger = (state_reg == ST_DONE);
endmodule

// File: tb/tb_timer_fsm_param.sv
// tb_timer_fsm_param: self-checking bench for timer_fsm_param.
// Two instances share clock and reset: dut_a with PRESCALE=1, dut_b with
// PRESCALE=4. Expected observations are pushed to a queue as each cycle's
// stimulus is driven and popped for comparison after the clock edge.
// With TIMER_FSM_AUTORELOAD_EN defined the DONE expectations follow the
// reload behaviour and an extra periodic-trigger scenario runs.
module tb_timer_fsm_param;
    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        busy;
        logic        trig;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    timer_fsm_param_if #(.WIDTH(16)) a_if ();
    timer_fsm_param_if #(.WIDTH(16)) b_if ();

    timer_fsm_param #(.WIDTH(16), .PRESCALE(1)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (a_if.slave)
    );

    timer_fsm_param #(.WIDTH(16), .PRESCALE(4)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    // Expected observation from an expected state/count: busy and trigger
    // are decoded from the state as the interface description defines.
    function automatic obs_t mk(input int st, input int cnt);
        obs_t o;
        o.st   = st[1:0];
        o.cnt  = cnt[15:0];
        o.busy = (st == 1) || (st == 2);
        o.trig = (st == 3);
        return o;
    endfunction

    function automatic obs_t obs_a();
        return {a_if.state, a_if.count, a_if.busy, a_if.trigger};
    endfunction

    function automatic obs_t obs_b();
        return {b_if.state, b_if.count, b_if.busy, b_if.trigger};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t g;
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0));
        e = exp_q.pop_front(); g = obs_a(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_a: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                     g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
        end else $display("reset_a st=%0d cnt=%0d", g.st, g.cnt);
        exp_q.push_back(mk(0, 0));
        e = exp_q.pop_front(); g = obs_b(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_b: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                     g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
        end else $display("reset_b st=%0d cnt=%0d", g.st, g.cnt);
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        a_if.enable = 1'b1;
        exp_q.push_back(mk(0, 0));
        tick();
        e = exp_q.pop_front(); g = obs_a(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_release: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                     g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
        end else $display("reset_release st=%0d cnt=%0d", g.st, g.cnt);
    endtask

    task automatic test_basic();
        obs_t e;
        obs_t g;
        a_if.load_value = 16'd5;
        a_if.enable     = 1'b1;
        a_if.start      = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 0)      exp_q.push_back(mk(1, 5));
            else if (k < 5)  exp_q.push_back(mk(1, 5 - k));
            else if (k == 5) exp_q.push_back(mk(3, 0));
            else begin
`ifdef TIMER_FSM_AUTORELOAD_EN
                exp_q.push_back(mk(1, 5 - (k - 6)));
`else
                exp_q.push_back(mk(3, 0));
`endif
            end
            tick();
            a_if.start = 1'b0;
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic[%0d]: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                         k, g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
            end else $display("basic[%0d] st=%0d cnt=%0d trig=%b", k, g.st, g.cnt, g.trig);
        end
        a_if.clear = 1'b1;
        exp_q.push_back(mk(0, 0));
        tick();
        a_if.clear = 1'b0;
        e = exp_q.pop_front(); g = obs_a(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL basic_clear: got st=%0d cnt=%0d, expected st=%0d cnt=%0d", g.st, g.cnt, e.st, e.cnt);
        end else $display("basic_clear st=%0d cnt=%0d", g.st, g.cnt);
    endtask

    task automatic test_pause();
        obs_t e;
        obs_t g;
        // Row 0 is the start edge; enable drops for three edges once count is 7.
        int en[15] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        int es[15] = '{1, 1, 1, 1, 2, 2, 2, 1, 1, 1, 1, 1, 1, 1, 3};
        int ec[15] = '{10, 9, 8, 7, 7, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0};
        a_if.load_value = 16'd10;
        a_if.start      = 1'b1;
        for (int k = 0; k < 15; k++) begin
            a_if.enable = en[k][0];
            exp_q.push_back(mk(es[k], ec[k]));
            tick();
            a_if.start = 1'b0;
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pause[%0d]: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                         k, g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
            end else $display("pause[%0d] st=%0d cnt=%0d", k, g.st, g.cnt);
        end
        a_if.enable = 1'b1;
        a_if.clear  = 1'b1;
        tick();
        a_if.clear  = 1'b0;
    endtask

    task automatic test_prescaler();
        obs_t e;
        obs_t g;
        b_if.load_value = 16'd3;
        b_if.enable     = 1'b1;
        b_if.start      = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k == 0)       exp_q.push_back(mk(1, 3));
            else if (k == 12) exp_q.push_back(mk(3, 0));
            else              exp_q.push_back(mk(1, 3 - k / 4));
            tick();
            b_if.start = 1'b0;
            e = exp_q.pop_front(); g = obs_b(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL prescale[%0d]: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                         k, g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
            end else $display("prescale[%0d] st=%0d cnt=%0d", k, g.st, g.cnt);
        end
        b_if.clear = 1'b1;
        tick();
        b_if.clear = 1'b0;
    endtask

    task automatic test_priority();
        obs_t e;
        obs_t g;
        int clr[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int sta[14] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
        int en[14]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        int ld[14]  = '{9, 9, 9, 9, 0, 0, 4, 4, 4, 2, 2, 6, 6, 6};
        int es[14]  = '{1, 1, 0, 0, 3, 3, 2, 2, 0, 1, 1, 1, 1, 0};
        int ec[14]  = '{9, 8, 0, 0, 0, 0, 4, 4, 0, 2, 1, 6, 5, 0};
        for (int k = 0; k < 14; k++) begin
            a_if.clear      = clr[k][0];
            a_if.start      = sta[k][0];
            a_if.enable     = en[k][0];
            a_if.load_value = ld[k][15:0];
            exp_q.push_back(mk(es[k], ec[k]));
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL priority[%0d]: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                         k, g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
            end else $display("priority[%0d] st=%0d cnt=%0d", k, g.st, g.cnt);
        end
        a_if.clear = 1'b0;
        a_if.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t e;
        obs_t g;
        a_if.load_value = 16'd6;
        a_if.enable     = 1'b1;
        a_if.start      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(1, 6 - k));
            tick();
            a_if.start = 1'b0;
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL resetmid_run[%0d]: got st=%0d cnt=%0d, expected st=%0d cnt=%0d", k, g.st, g.cnt, e.st, e.cnt);
            end else $display("resetmid_run[%0d] st=%0d cnt=%0d", k, g.st, g.cnt);
        end
        // Assert reset between edges: outputs must clear without waiting for clk.
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0));
        e = exp_q.pop_front(); g = obs_a(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL resetmid_async: got st=%0d cnt=%0d busy=%b trig=%b, expected st=%0d cnt=%0d busy=%b trig=%b",
                     g.st, g.cnt, g.busy, g.trig, e.st, e.cnt, e.busy, e.trig);
        end else $display("resetmid_async st=%0d cnt=%0d", g.st, g.cnt);
        tick();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 0));
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL resetmid_idle[%0d]: got st=%0d cnt=%0d, expected st=%0d cnt=%0d", k, g.st, g.cnt, e.st, e.cnt);
            end else $display("resetmid_idle[%0d] st=%0d cnt=%0d", k, g.st, g.cnt);
        end
    endtask

`ifdef TIMER_FSM_AUTORELOAD_EN
    task automatic test_autoreload();
        obs_t e;
        obs_t g;
        a_if.load_value = 16'd2;
        a_if.enable     = 1'b1;
        a_if.start      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0)      exp_q.push_back(mk(1, 2));
            else if (k % 3 == 1) exp_q.push_back(mk(1, 1));
            else                 exp_q.push_back(mk(3, 0));
            tick();
            a_if.start = 1'b0;
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL autoreload[%0d]: got st=%0d cnt=%0d trig=%b, expected st=%0d cnt=%0d trig=%b",
                         k, g.st, g.cnt, g.trig, e.st, e.cnt, e.trig);
            end else $display("autoreload[%0d] st=%0d cnt=%0d trig=%b", k, g.st, g.cnt, g.trig);
        end
        a_if.clear = 1'b1;
        tick();
        a_if.clear = 1'b0;
    endtask
`endif

    initial begin
        a_if.enable = 1'b0; a_if.start = 1'b0; a_if.clear = 1'b0; a_if.load_value = '0;
        b_if.enable = 1'b0; b_if.start = 1'b0; b_if.clear = 1'b0; b_if.load_value = '0;
        test_reset();
        test_basic();
        test_pause();
        test_prescaler();
        test_priority();
        test_reset_mid();
`ifdef TIMER_FSM_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
